// File: rtl/toggle_window_counter.sv
// toggle_window_counter: edge pulses and windowed toggle count of a T flip-flop Q.
// Ports: clk, reset (sync, high); q_in, en, win_len in; rise_pulse, fall_pulse out;
//   count_out/count_valid/count_ready result handshake; overflow, dropped status flags.
module toggle_window_counter #(
    parameter int CNT_W = 8,
    parameter int WIN_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             q_in,
    input  logic             en,
    input  logic [WIN_W-1:0] win_len,
    output logic             rise_pulse,
    output logic             fall_pulse,
    output logic [CNT_W-1:0] count_out,
    output logic             count_valid,
    input  logic             count_ready,
    output logic             overflow,
    output logic             dropped
);

    typedef enum logic [1:0] {
        IDLE,
        COUNT,
        HOLD
    } state_t;

    localparam logic [CNT_W-1:0] ACC_MAX = '1;

    state_t state_q, state_d;

    logic             q_dly_q;
    logic             rise_q, fall_q;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             valid_q, valid_d;
    logic             ovf_q, ovf_d;
    logic             drop_q, drop_d;
    logic [WIN_W-1:0] win_q, win_d;
    logic [CNT_W-1:0] acc_q, acc_d;
    logic             sat_q, sat_d;

    logic             tgl;
    logic             start_ok;
    logic             acc_full;
    logic [CNT_W-1:0] acc_inc;
    logic             sat_inc;
    logic             last;
    logic             hshake;

    assign tgl      = q_in ^ q_dly_q;
    assign start_ok = en && (win_len != '0);
    assign acc_full = (acc_q == ACC_MAX);
    // Accumulator value including this cycle's toggle, clamped at full scale.
    assign acc_inc  = (tgl && !acc_full) ? acc_q + CNT_W'(1) : acc_q;
    assign sat_inc  = sat_q | (tgl & acc_full);
    assign last     = (win_q == WIN_W'(1));
    assign hshake   = valid_q & count_ready;

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (start_ok) begin
                    state_d = COUNT;
                end
            end
            COUNT: begin
                // Losing enable abandons the window even on its final cycle.
                if (!en) begin
                    state_d = IDLE;
                end else if (last) begin
                    state_d = HOLD;
                end
            end
            HOLD: begin
                if (hshake) begin
                    state_d = start_ok ? COUNT : IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Datapath / output next-state logic
    always_comb begin
        win_d   = win_q;
        acc_d   = acc_q;
        sat_d   = sat_q;
        cnt_d   = cnt_q;
        valid_d = valid_q;
        ovf_d   = ovf_q;
        drop_d  = drop_q;
        unique case (state_q)
            IDLE: begin
                if (start_ok) begin
                    win_d = win_len;
                    acc_d = '0;
                    sat_d = 1'b0;
                end
            end
            COUNT: begin
                if (en) begin
                    if (last) begin
                        cnt_d   = acc_inc;
                        ovf_d   = sat_inc;
                        valid_d = 1'b1;
                    end else begin
                        win_d = win_q - WIN_W'(1);
                        acc_d = acc_inc;
                        sat_d = sat_inc;
                    end
                end
            end
            HOLD: begin
                // Nobody is counting while the result waits; flag the loss.
                if (tgl) begin
                    drop_d = 1'b1;
                end
                if (hshake) begin
                    valid_d = 1'b0;
                    if (start_ok) begin
                        win_d = win_len;
                        acc_d = '0;
                        sat_d = 1'b0;
                    end
                end
            end
            default: ;
        endcase
    end

    // Datapath / output registers
    always_ff @(posedge clk) begin
        if (reset) begin
            q_dly_q <= 1'b0;
            rise_q  <= 1'b0;
            fall_q  <= 1'b0;
            cnt_q   <= '0;
            valid_q <= 1'b0;
            ovf_q   <= 1'b0;
            drop_q  <= 1'b0;
            win_q   <= '0;
            acc_q   <= '0;
            sat_q   <= 1'b0;
        end else begin
            q_dly_q <= q_in;
            rise_q  <= q_in & ~q_dly_q;
            fall_q  <= ~q_in & q_dly_q;
            cnt_q   <= cnt_d;
            valid_q <= valid_d;
            ovf_q   <= ovf_d;
            drop_q  <= drop_d;
            win_q   <= win_d;
            acc_q   <= acc_d;
            sat_q   <= sat_d;
        end
    end

    assign rise_pulse  = rise_q;
    assign fall_pulse  = fall_q;
    assign count_out   = cnt_q;
    assign count_valid = valid_q;
    assign overflow    = ovf_q;
    assign dropped     = drop_q;

endmodule

// File: tb/tb_toggle_window_counter.sv
// tb_toggle_window_counter: directed bench with a result scoreboard.
// Drives both an 8-bit and a 4-bit count instance from shared inputs.
module tb_toggle_window_counter;

    logic       clk = 1'b0;
    logic       reset;
    logic       q_in;
    logic       en;
    logic [7:0] win_len;
    logic       count_ready;

    logic       rise8, fall8, valid8, ovf8, drop8;
    logic [7:0] cnt8;
    logic       rise4, fall4, valid4, ovf4, drop4;
    logic [3:0] cnt4;

    int total = 0;
    int bad   = 0;

    typedef struct packed {
        logic [7:0] cnt;
        logic       ovf;
    } res_t;

    res_t sb[$];
    res_t exp_r;
    logic pv8 = 1'b0;

    toggle_window_counter #(.CNT_W(8), .WIN_W(8)) dut8 (
        .clk(clk), .reset(reset), .q_in(q_in), .en(en),
        .win_len(win_len), .rise_pulse(rise8), .fall_pulse(fall8),
        .count_out(cnt8), .count_valid(valid8),
        .count_ready(count_ready), .overflow(ovf8), .dropped(drop8)
    );

    toggle_window_counter #(.CNT_W(4), .WIN_W(8)) dut4 (
        .clk(clk), .reset(reset), .q_in(q_in), .en(en),
        .win_len(win_len), .rise_pulse(rise4), .fall_pulse(fall4),
        .count_out(cnt4), .count_valid(valid4),
        .count_ready(count_ready), .overflow(ovf4), .dropped(drop4)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_rise"},  32'(rise8),  0);
        chk({tag, "_fall"},  32'(fall8),  0);
        chk({tag, "_cnt"},   32'(cnt8),   0);
        chk({tag, "_valid"}, 32'(valid8), 0);
        chk({tag, "_ovf"},   32'(ovf8),   0);
        chk({tag, "_drop"},  32'(drop8),  0);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        q_in  = 1'b0;
        en    = 1'b0;
        count_ready = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic wait_drain(input int budget);
        int n = 0;
        while (sb.size() != 0 && n < budget) begin
            @(negedge clk);
            n++;
        end
        total++;
        assert (sb.size() == 0) else begin
            bad++;
            $error("FAIL drain_timeout got=%0d pending exp=0", sb.size());
        end
    endtask

    // Scoreboard monitor: every new result on the 8-bit instance is matched.
    always @(negedge clk) begin
        if (valid8 === 1'b1 && pv8 !== 1'b1) begin
            total++;
            assert (sb.size() != 0) else begin
                bad++;
                $error("FAIL unexpected_result got=%0h exp=none", cnt8);
            end
            if (sb.size() != 0) begin
                exp_r = sb.pop_front();
                chk("res_cnt", 32'(cnt8), 32'(exp_r.cnt));
                chk("res_ovf", 32'(ovf8), 32'(exp_r.ovf));
            end
        end
        pv8 = valid8;
    end

    initial begin
        #50000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int rises;
        int falls;
        int vcnt;

        // Reset with q_in toggling
        reset = 1'b1;
        q_in  = 1'b0;
        en    = 1'b0;
        win_len = 8'd0;
        count_ready = 1'b1;
        @(negedge clk);
        q_in = 1'b1;
        @(negedge clk);
        chk_zero("rst_a");
        chk("rst4_cnt", 32'(cnt4), 0);
        chk("rst4_valid", 32'(valid4), 0);
        q_in = 1'b0;
        @(negedge clk);
        chk("rst_b_rise", 32'(rise8), 0);
        reset = 1'b0;
        q_in  = 1'b1;
        @(negedge clk);
        chk("post_rst_rise", 32'(rise8), 1);
        chk("post_rst_fall", 32'(fall8), 0);
        q_in = 1'b0;
        @(negedge clk);
        chk("post_rst_rise0", 32'(rise8), 0);
        chk("post_rst_fall1", 32'(fall8), 1);

        // Toggle every cycle, win_len=8, two back-to-back windows
        do_reset();
        reset = 1'b0;
        en = 1'b1;
        win_len = 8'd8;
        q_in = ~q_in;
        sb.push_back('{cnt: 8'd8, ovf: 1'b0});
        sb.push_back('{cnt: 8'd8, ovf: 1'b0});
        for (int i = 0; i <= 21; i++) begin
            @(negedge clk);
            q_in = ~q_in;
            if (i == 8) chk("t2_valid_a", 32'(valid8), 1);
            if (i == 9) begin
                chk("t2_pulse_1cyc", 32'(valid8), 0);
                chk("t2_cnt_hold", 32'(cnt8), 8);
            end
            if (i == 17) chk("t2_valid_b", 32'(valid8), 1);
            if (i == 21) en = 1'b0;
        end
        wait_drain(20);

        // Single rising toggle at window cycle 3 of win_len=10
        do_reset();
        reset = 1'b0;
        en = 1'b1;
        win_len = 8'd10;
        rises = 0;
        falls = 0;
        sb.push_back('{cnt: 8'd1, ovf: 1'b0});
        for (int i = 0; i <= 14; i++) begin
            @(negedge clk);
            rises += int'(rise8);
            falls += int'(fall8);
            if (i == 2) q_in = 1'b1;
            if (i == 3) chk("t3_rise_lat", 32'(rise8), 1);
            if (i == 10) begin
                chk("t3_valid", 32'(valid8), 1);
                chk("t3_cnt", 32'(cnt8), 1);
                en = 1'b0;
            end
        end
        chk("t3_rises", 32'(rises), 1);
        chk("t3_falls", 32'(falls), 0);
        wait_drain(20);

        // Saturation: win_len=20 on the 4-bit instance
        do_reset();
        reset = 1'b0;
        en = 1'b1;
        win_len = 8'd20;
        q_in = ~q_in;
        sb.push_back('{cnt: 8'd20, ovf: 1'b0});
        for (int i = 0; i <= 20; i++) begin
            @(negedge clk);
            q_in = ~q_in;
            if (i == 20) begin
                chk("t4_valid4", 32'(valid4), 1);
                chk("t4_cnt4", 32'(cnt4), 15);
                chk("t4_ovf4", 32'(ovf4), 1);
                chk("t4_valid8", 32'(valid8), 1);
                chk("t4_ovf8", 32'(ovf8), 0);
                en = 1'b0;
            end
        end
        wait_drain(20);

        // Back-pressure in HOLD with toggling input
        do_reset();
        reset = 1'b0;
        en = 1'b1;
        win_len = 8'd8;
        count_ready = 1'b0;
        q_in = ~q_in;
        sb.push_back('{cnt: 8'd8, ovf: 1'b0});
        for (int i = 0; i <= 22; i++) begin
            @(negedge clk);
            q_in = ~q_in;
            if (i == 8) chk("t5_drop_pre", 32'(drop8), 0);
            if (i >= 9 && i <= 13) begin
                chk("t5_hold_valid", 32'(valid8), 1);
                chk("t5_hold_cnt", 32'(cnt8), 8);
            end
            if (i == 13) begin
                chk("t5_dropped", 32'(drop8), 1);
                count_ready = 1'b1;
                sb.push_back('{cnt: 8'd8, ovf: 1'b0});
            end
            if (i == 14) chk("t5_valid_clr", 32'(valid8), 0);
            if (i == 22) begin
                chk("t5_valid_b", 32'(valid8), 1);
                chk("t5_cnt_b", 32'(cnt8), 8);
                chk("t5_drop_sticky", 32'(drop8), 1);
                en = 1'b0;
            end
        end
        wait_drain(20);

        // Enable dropped at COUNT cycle 4: no result
        do_reset();
        reset = 1'b0;
        en = 1'b1;
        win_len = 8'd8;
        q_in = ~q_in;
        vcnt = 0;
        for (int i = 0; i <= 15; i++) begin
            @(negedge clk);
            q_in = ~q_in;
            vcnt += int'(valid8);
            if (i == 3) en = 1'b0;
        end
        chk("t6_no_valid", 32'(vcnt), 0);
        chk("t6_cnt", 32'(cnt8), 0);

        // Reset in the middle of a second window
        en = 1'b1;
        sb.push_back('{cnt: 8'd8, ovf: 1'b0});
        for (int i = 0; i <= 13; i++) begin
            @(negedge clk);
            q_in = ~q_in;
            if (i == 12) begin
                chk("t6b_cnt_pre", 32'(cnt8), 8);
                chk("t6b_drop_pre", 32'(drop8), 1);
                chk("t6b_valid_pre", 32'(valid8), 0);
                reset = 1'b1;
                en = 1'b0;
            end
            if (i == 13) chk_zero("t6b_rst");
        end
        reset = 1'b0;
        wait_drain(5);

        // win_len=0 keeps the block idle; then a 2-cycle window
        en = 1'b1;
        win_len = 8'd0;
        vcnt = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            q_in = ~q_in;
            vcnt += int'(valid8);
        end
        chk("t7_zero_win", 32'(vcnt), 0);
        win_len = 8'd2;
        sb.push_back('{cnt: 8'd2, ovf: 1'b0});
        for (int i = 0; i <= 2; i++) begin
            @(negedge clk);
            q_in = ~q_in;
            if (i == 2) begin
                chk("t7_valid", 32'(valid8), 1);
                chk("t7_cnt", 32'(cnt8), 2);
                en = 1'b0;
            end
        end
        wait_drain(10);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
